// File: rtl/cpu4_pkg.sv
// Shared types and decode helpers for the nibble-bus CPU sequencer.
// Opcodes, bus-phase mirror states and top-level controller states.
package cpu4_pkg;

  localparam int AW = 6;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_INC  = 4'h1;
  localparam logic [3:0] OP_DEC  = 4'h2;
  localparam logic [3:0] OP_NOT  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_CLR  = 4'h6;
  localparam logic [3:0] OP_SWP  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_SUBI = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_LDA  = 4'hC;
  localparam logic [3:0] OP_LDB  = 4'hD;
  localparam logic [3:0] OP_STA  = 4'hE;
  localparam logic [3:0] OP_STB  = 4'hF;

  typedef enum logic [1:0] {
    ADDR,
    OP,
    MEM1,
    MEM2
  } phase_e;

  typedef enum logic [1:0] {
    IDLE,
    RESET_CPU,
    RUN
  } top_e;

  function automatic logic is_store(input logic [3:0] op);
    return op[3:1] == 3'b111;
  endfunction

  function automatic logic is_jump(input logic [3:0] op);
    return op[3:1] == 3'b101;
  endfunction

endpackage

// File: rtl/cpu4_nibble_ram.sv
// 64x4 program/data store: one synchronous write port,
// an asynchronous fetch read and a registered host read.
module cpu4_nibble_ram
  import cpu4_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [3:0]    wdata_i,
  input  logic [AW-1:0] faddr_i,
  output logic [3:0]    fdata_o,
  input  logic [AW-1:0] raddr_i,
  output logic [3:0]    rdata_o
);

  logic [3:0] mem_q [DEPTH];
  logic [3:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Host read sees the pre-write contents of a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= mem_q[raddr_i];
  end

  assign fdata_o = mem_q[faddr_i];
  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu4_bus_sequencer.sv
// Sequencer for the nibble-bus CPU: clocks/resets the core, feeds
// instruction and operand nibbles, captures stores, serves the host.
module cpu4_bus_sequencer
  import cpu4_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int DATA_BASE = 48,
  parameter int STEP_DIV  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [3:0]    ld_data,
  input  logic [AW-1:0] rd_addr,
  output logic [3:0]    rd_data,
  input  logic          run_start,
  input  logic          run_stop,
  output logic          running,
  output logic          cpu_clk,
  output logic          cpu_rst,
  output logic [3:0]    cpu_data,
  input  logic [AW-1:0] cpu_bus,
  input  logic          cpu_wcyc,
  output logic [15:0]   cycle_cnt
);

  localparam int DW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
  localparam logic [AW-1:0] BASE = AW'(DATA_BASE);

  top_e          state_q, state_d;
  phase_e        phase_q, phase_d;
  logic          rcnt_q, rcnt_d;
  logic [DW-1:0] div_q, div_d;
  logic [AW-1:0] fptr_q, fptr_d;
  logic [AW-1:0] pcs_q, pcs_d;
  logic [AW-1:0] bus_q, bus_d;
  logic          wcyc_q, wcyc_d;
  logic [3:0]    op_q, op_d;
  logic [3:0]    opnd_q, opnd_d;
  logic [15:0]   cnt_q, cnt_d;

  logic          tick, smp, st_hit, st_we;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [3:0]    mem_wdata, fdata;

  assign tick   = (state_q == RUN) && (div_q == DIV_LAST);
  assign smp    = (state_q == RUN) && (div_q == '0);
  assign st_hit = (phase_q == ADDR) && is_store(op_q) && wcyc_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rcnt_d  = rcnt_q;
    div_d   = div_q;
    fptr_d  = fptr_q;
    pcs_d   = pcs_q;
    bus_d   = bus_q;
    wcyc_d  = wcyc_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    st_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run_start && !run_stop) begin
          state_d = RESET_CPU;
          phase_d = ADDR;
          rcnt_d  = 1'b0;
          div_d   = '0;
          fptr_d  = '0;
          pcs_d   = '0;
          bus_d   = '0;
          wcyc_d  = 1'b0;
          op_d    = OP_NOP;
          opnd_d  = '0;
          cnt_d   = '0;
        end
      end
      RESET_CPU: begin
        if (run_stop)    state_d = IDLE;
        else if (rcnt_q) state_d = RUN;
        else             rcnt_d  = 1'b1;
      end
      RUN: begin
        if (run_stop) begin
          state_d = IDLE;
          div_d   = '0;
        end else begin
          div_d = tick ? '0 : div_q + DW'(1);
          if (smp) begin
            bus_d  = cpu_bus;
            wcyc_d = cpu_wcyc;
          end
          if (tick) begin
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            unique case (phase_q)
              ADDR: begin
                // A store cycle drives data, not the pc, on the bus.
                if (st_hit) begin
                  st_we = 1'b1;
                end else if (bus_q != pcs_q) begin
                  fptr_d = bus_q;
                  pcs_d  = bus_q;
                end
                phase_d = OP;
              end
              OP: begin
                op_d    = fdata;
                fptr_d  = fptr_q + AW'(1);
                phase_d = fdata[3] ? MEM1 : ADDR;
              end
              MEM1: begin
                opnd_d  = fdata;
                fptr_d  = fptr_q + AW'(1);
                phase_d = is_jump(op_q) ? MEM2 : ADDR;
              end
              MEM2: begin
                fptr_d  = fptr_q + AW'(1);
                phase_d = ADDR;
              end
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= ADDR;
      rcnt_q  <= 1'b0;
      div_q   <= '0;
      fptr_q  <= '0;
      pcs_q   <= '0;
      bus_q   <= '0;
      wcyc_q  <= 1'b0;
      op_q    <= OP_NOP;
      opnd_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rcnt_q  <= rcnt_d;
      div_q   <= div_d;
      fptr_q  <= fptr_d;
      pcs_q   <= pcs_d;
      bus_q   <= bus_d;
      wcyc_q  <= wcyc_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ld_ready  = (state_q == IDLE) && ld_valid;
  assign mem_we    = st_we || ld_ready;
  assign mem_waddr = st_we ? BASE + AW'(opnd_q) : ld_addr;
  assign mem_wdata = st_we ? bus_q[3:0] : ld_data;

  cpu4_nibble_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .faddr_i (fptr_q),
    .fdata_o (fdata),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign running   = (state_q != IDLE);
  assign cpu_clk   = tick;
  assign cpu_rst   = (state_q != RUN);
  assign cpu_data  = ((state_q == RUN) && (phase_q != ADDR)) ? fdata : 4'h0;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_cpu4_bus_sequencer.sv
// Directed bench for cpu4_bus_sequencer: host port, fetch sequencing,
// store capture, jump redirect, arbitration, wrap and async reset.
module tb_cpu4_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [5:0]  ld_addr = '0;
  logic [3:0]  ld_data = '0;
  logic [5:0]  rd_addr = '0;
  logic [3:0]  rd_data;
  logic        run_start = 1'b0;
  logic        run_stop = 1'b0;
  logic        running;
  logic        cpu_clk;
  logic        cpu_rst;
  logic [3:0]  cpu_data;
  logic [5:0]  cpu_bus = '0;
  logic        cpu_wcyc = 1'b0;
  logic [15:0] cycle_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  cpu4_bus_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .run_start (run_start),
    .run_stop  (run_stop),
    .running   (running),
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .cpu_data  (cpu_data),
    .cpu_bus   (cpu_bus),
    .cpu_wcyc  (cpu_wcyc),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [5:0] a, input logic [3:0] d);
    ld_addr  = a;
    ld_data  = d;
    ld_valid = 1'b1;
    step();
    ld_valid = 1'b0;
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (cpu_clk !== 1'b1 && k < 8);
    chk("cpu_clk_tick", 16'(cpu_clk), 16'd1);
  endtask

  task automatic run_sb(input int n);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      wait_tick();
      e = exp_q.pop_front();
      chk("cpu_data", 16'(cpu_data), 16'(e));
    end
  endtask

  task automatic start_run();
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    chk("start_running", 16'(running), 16'd1);
    chk("start_rst1", 16'(cpu_rst), 16'd1);
    chk("start_cnt0", cycle_cnt, 16'd0);
    step();
    chk("start_rst2", 16'(cpu_rst), 16'd1);
    step();
    chk("start_rst_rel", 16'(cpu_rst), 16'd0);
  endtask

  task automatic stop_run();
    run_stop = 1'b1;
    step();
    run_stop = 1'b0;
    chk("stop_running", 16'(running), 16'd0);
    chk("stop_cpu_clk", 16'(cpu_clk), 16'd0);
    chk("stop_cpu_rst", 16'(cpu_rst), 16'd1);
    chk("stop_cpu_data", 16'(cpu_data), 16'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    step();
    step();
    chk("rst_ld_ready", 16'(ld_ready), 16'd0);
    chk("rst_rd_data", 16'(rd_data), 16'd0);
    chk("rst_running", 16'(running), 16'd0);
    chk("rst_cpu_clk", 16'(cpu_clk), 16'd0);
    chk("rst_cpu_rst", 16'(cpu_rst), 16'd1);
    chk("rst_cpu_data", 16'(cpu_data), 16'd0);
    chk("rst_cycle_cnt", cycle_cnt, 16'd0);
    rst_n = 1'b1;
    step();
    for (int a = 0; a < 64; a++) load(6'(a), 4'h0);

    // host load and same-cycle read of the written address
    ld_addr  = 6'd5;
    ld_data  = 4'hC;
    rd_addr  = 6'd5;
    ld_valid = 1'b1;
    #1;
    chk("ld_ready_idle", 16'(ld_ready), 16'd1);
    step();
    ld_valid = 1'b0;
    chk("rd_old_value", 16'(rd_data), 16'h0);
    step();
    chk("rd_new_value", 16'(rd_data), 16'hC);

    // LDA: two-nibble instruction, then fall-through fetch
    load(6'd0, 4'hC);
    load(6'd1, 4'h7);
    load(6'd2, 4'h3);
    exp_q.push_back(4'h0);
    exp_q.push_back(4'hC);
    exp_q.push_back(4'h7);
    exp_q.push_back(4'h0);
    exp_q.push_back(4'h3);
    start_run();
    run_sb(4);
    chk("lda_cycle_cnt", cycle_cnt, 16'd3);
    run_sb(1);
    stop_run();

    // store capture into DATA_BASE+opnd, no redirect
    load(6'd0, 4'hE);
    load(6'd1, 4'h3);
    load(6'd2, 4'h5);
    exp_q.push_back(4'h0);
    exp_q.push_back(4'hE);
    exp_q.push_back(4'h3);
    exp_q.push_back(4'h0);
    exp_q.push_back(4'h5);
    start_run();
    run_sb(3);
    cpu_bus  = 6'h09;
    cpu_wcyc = 1'b1;
    run_sb(1);
    cpu_bus  = 6'h00;
    cpu_wcyc = 1'b0;
    run_sb(1);
    stop_run();
    rd_addr = 6'd51;
    step();
    chk("store_mem51", 16'(rd_data), 16'h9);

    // jump redirect, then no re-redirect once pc_shadow matches
    load(6'd0, 4'h1);
    load(6'd20, 4'h6);
    load(6'd21, 4'h2);
    cpu_bus = 6'h14;
    exp_q.push_back(4'h0);
    exp_q.push_back(4'h6);
    exp_q.push_back(4'h0);
    exp_q.push_back(4'h2);
    start_run();
    run_sb(4);
    stop_run();
    cpu_bus = 6'h00;

    // simultaneous start and stop: stop wins
    run_start = 1'b1;
    run_stop  = 1'b1;
    step();
    run_start = 1'b0;
    run_stop  = 1'b0;
    chk("startstop_running", 16'(running), 16'd0);
    chk("startstop_cpu_rst", 16'(cpu_rst), 16'd1);

    // host write stalls during RUN, accepted after stop
    load(6'd7, 4'h4);
    rd_addr = 6'd7;
    exp_q.push_back(4'h0);
    exp_q.push_back(4'h1);
    start_run();
    ld_addr  = 6'd7;
    ld_data  = 4'hD;
    ld_valid = 1'b1;
    run_sb(2);
    chk("run_ld_ready", 16'(ld_ready), 16'd0);
    chk("run_mem_kept", 16'(rd_data), 16'h4);
    stop_run();
    chk("post_stop_ld_ready", 16'(ld_ready), 16'd1);
    step();
    ld_valid = 1'b0;
    step();
    chk("post_stop_write", 16'(rd_data), 16'hD);

    // fetch pointer wraps 63 -> 0, then async reset mid-MEM1
    load(6'd63, 4'h8);
    load(6'd0, 4'h9);
    cpu_bus = 6'd63;
    exp_q.push_back(4'h0);
    exp_q.push_back(4'h8);
    exp_q.push_back(4'h9);
    start_run();
    run_sb(3);
    rst_n = 1'b0;
    #1;
    chk("arst_running", 16'(running), 16'd0);
    chk("arst_cpu_clk", 16'(cpu_clk), 16'd0);
    chk("arst_cpu_rst", 16'(cpu_rst), 16'd1);
    chk("arst_cpu_data", 16'(cpu_data), 16'd0);
    chk("arst_cycle_cnt", cycle_cnt, 16'd0);
    chk("arst_ld_ready", 16'(ld_ready), 16'd0);
    chk("arst_rd_data", 16'(rd_data), 16'd0);
    cpu_bus = 6'h00;
    step();
    rst_n   = 1'b1;
    rd_addr = 6'd5;
    step();
    step();
    chk("mem5_kept", 16'(rd_data), 16'hC);
    rd_addr = 6'd51;
    step();
    chk("mem51_kept", 16'(rd_data), 16'h9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
